frame_serializer: RTL and testbench
===================================

FRAME_SERIALIZER -- requirements
Module: frame_serializer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: request to send one frame; sampled on the rising edge.
REQ-004 SHALL have port len, input, 3 bits: length field L; the frame carries L+1 payload bits.
REQ-005 SHALL have port data, input, 8 bits: payload, sent MSB-first.
REQ-006 SHALL have port serout, output, 1 bit: serial line; 1 when idle.
REQ-007 SHALL have port busy, output, 1 bit: high from the cycle after start is accepted until DONE is left.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a frame.
REQ-009 SHALL have port state, output, 3 bits: current FSM state code, for debug.

Function
REQ-010 SHALL implement these states and codes: IDLE=0, START=1, HDR=2, DATA=3, PAR=4, DONE=5; codes 6 and 7 SHALL go to IDLE on the next edge.
REQ-011 SHALL accept start only in IDLE: at that edge, latch len and data into internal registers and enter START.
REQ-012 SHALL ignore start in every state other than IDLE; a frame in progress is neither aborted nor queued.
REQ-013 START SHALL last 1 cycle with serout=0 (start bit).
REQ-014 HDR SHALL last exactly 3 cycles, driving the latched L on serout MSB-first; the bit index comes from a 2-bit down-counter.
REQ-015 DATA SHALL last exactly L+1 cycles, driving latched data[7], data[6], ... data[7-L] in order.
REQ-016 DATA SHALL track its bit count with a 3-bit counter compared against the latched L; L=0 gives 1 bit and L=7 gives 8 bits, with no wrap-around error.
REQ-017 DONE SHALL last 1 cycle with serout=1 and done=1, then go to IDLE.
REQ-018 In DONE, busy SHALL be 1; a start asserted in DONE SHALL be ignored.
REQ-019 In IDLE, serout SHALL be 1, busy 0 and done 0.
REQ-020 Changes on len and data after acceptance SHALL NOT affect the frame in progress.
REQ-021 serout, busy and done SHALL be registered outputs with no combinational path from any input.
REQ-022 Latency SHALL be fixed: the start bit appears on serout in the cycle immediately after the accepting edge.

Reset
REQ-023 Asserting rst SHALL immediately force state=IDLE, serout=1, busy=0, done=0, and clear all counters and latched registers to 0, including mid-frame.
REQ-024 A frame interrupted by reset SHALL be discarded; after rst deasserts, the block SHALL wait for a new start.

Configuration
REQ-025 The macro FRAME_SERIALIZER_PARITY_EN SHALL control the PAR state.
REQ-026 When FRAME_SERIALIZER_PARITY_EN is defined, PAR SHALL follow DATA for 1 cycle, driving even parity over the L+1 transmitted payload bits; header bits are excluded.
REQ-027 When FRAME_SERIALIZER_PARITY_EN is undefined, DATA SHALL go directly to DONE and code 4 SHALL be unreachable; it falls under the REQ-010 recovery rule.

Verification
REQ-028 Macro off, len=7, data=8'hA5, start pulsed at edge k: serout SHALL be 0,1,1,1,1,0,1,0,0,1,0,1 on cycles k+1..k+12, with done=1 only on cycle k+13.
REQ-029 Macro off, len=0, data=8'h80: serout SHALL be 0,0,0,0,1 and then the DONE 1; the frame occupies 6 cycles from start bit to DONE.
REQ-030 Macro on, len=2, data=8'hC0 (payload bits 1,1,0): the parity bit SHALL be 0; with data=8'hE0 (bits 1,1,1) the parity bit SHALL be 1, and done is delayed one cycle relative to the macro-off case.
REQ-031 With start held high continuously, frames SHALL be sent back-to-back, each separated by exactly one IDLE cycle with serout=1; start pulses during busy SHALL produce no extra frame.
REQ-032 rst asserted asynchronously in the middle of DATA: serout=1, busy=0 and state=0 SHALL hold before the next clock edge, and a following start SHALL produce a complete, correct frame.
REQ-033 Changing data on the cycle after acceptance SHALL leave the transmitted bits equal to the originally latched value.

Source files
------------

// File: rtl/frame_serializer.sv
// frame_serializer: sends one frame (start bit, 3-bit length header, L+1
// payload bits MSB-first, optional even-parity bit) on a single serial line.
// Optional feature: define FRAME_SERIALIZER_PARITY_EN to insert the PAR state
// between DATA and DONE. Default build (undefined) goes DATA -> DONE.
module frame_serializer (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] len,
  input  logic [7:0] data,
  output logic       serout,
  output logic       busy,
  output logic       done,
  output logic [2:0] state
);

  localparam int unsigned LEN_W  = 3;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned HCNT_W = 2;
  localparam int unsigned ST_W   = 3;

  typedef enum logic [ST_W-1:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_HDR   = 3'd2,
    S_DATA  = 3'd3,
    S_PAR   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              state_q, nxt_state;
  logic [LEN_W-1:0]    len_q, nxt_len;
  logic [DATA_W-1:0]   data_q, nxt_data;
  logic [HCNT_W-1:0]   hdr_cnt_q, nxt_hdr_cnt;
  logic [LEN_W-1:0]    bit_cnt_q, nxt_bit_cnt;
  logic                par_q, nxt_par;
  logic                cur_bit;
  logic                serout_q, busy_q, done_q;
  logic                serout_d, busy_d, done_d;

  // State, counters, latched frame fields and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      data_q    <= '0;
      hdr_cnt_q <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      serout_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= nxt_state;
      len_q     <= nxt_len;
      data_q    <= nxt_data;
      hdr_cnt_q <= nxt_hdr_cnt;
      bit_cnt_q <= nxt_bit_cnt;
      par_q     <= nxt_par;
      serout_q  <= serout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state, counter and latch updates
  always_comb begin
    nxt_state   = state_q;
    nxt_len     = len_q;
    nxt_data    = data_q;
    nxt_hdr_cnt = hdr_cnt_q;
    nxt_bit_cnt = bit_cnt_q;
    nxt_par     = par_q;
    cur_bit     = data_q[LEN_W'(3'd7 - bit_cnt_q)];
    case (state_q)
      S_IDLE: begin
        if (start) begin
          nxt_state = S_START;
          nxt_len   = len;
          nxt_data  = data;
        end
      end
      S_START: begin
        nxt_state   = S_HDR;
        nxt_hdr_cnt = HCNT_W'(2);
      end
      S_HDR: begin
        if (hdr_cnt_q == '0) begin
          nxt_state   = S_DATA;
          nxt_bit_cnt = '0;
          nxt_par     = 1'b0;
        end else begin
          nxt_hdr_cnt = hdr_cnt_q - HCNT_W'(1);
        end
      end
      S_DATA: begin
        // Running XOR of sent payload bits gives the even-parity bit
        nxt_par = par_q ^ cur_bit;
        if (bit_cnt_q == len_q) begin
`ifdef FRAME_SERIALIZER_PARITY_EN
          nxt_state = S_PAR;
`else
          nxt_state = S_DONE;
`endif
        end else begin
          nxt_bit_cnt = bit_cnt_q + LEN_W'(1);
        end
      end
`ifdef FRAME_SERIALIZER_PARITY_EN
      S_PAR: begin
        nxt_state = S_DONE;
      end
`endif
      S_DONE: begin
        nxt_state = S_IDLE;
      end
      default: begin
        nxt_state = S_IDLE;
      end
    endcase
  end

  // Output values for the upcoming state, registered so the start bit lands right after acceptance
  always_comb begin
    serout_d = 1'b1;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (nxt_state)
      S_START: begin
        serout_d = 1'b0;
        busy_d   = 1'b1;
      end
      S_HDR: begin
        serout_d = nxt_len[nxt_hdr_cnt];
        busy_d   = 1'b1;
      end
      S_DATA: begin
        serout_d = nxt_data[LEN_W'(3'd7 - nxt_bit_cnt)];
        busy_d   = 1'b1;
      end
      S_PAR: begin
        serout_d = nxt_par;
        busy_d   = 1'b1;
      end
      S_DONE: begin
        serout_d = 1'b1;
        busy_d   = 1'b1;
        done_d   = 1'b1;
      end
      default: begin
        serout_d = 1'b1;
      end
    endcase
  end

  assign serout = serout_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign state  = state_q;

endmodule

// File: tb/tb_frame_serializer.sv
// Directed bench for frame_serializer with hand-computed serial sequences.
module tb_frame_serializer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] len;
  logic [7:0] data;
  logic       serout;
  logic       busy;
  logic       done;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  frame_serializer dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .len    (len),
    .data   (data),
    .serout (serout),
    .busy   (busy),
    .done   (done),
    .state  (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sends one frame from an IDLE cycle; exp_bits holds n serout bits (start..last) MSB-first.
  // len/data are scrambled right after acceptance; hold keeps start high throughout.
  task automatic run_frame(input string tag, input logic [2:0] l, input logic [7:0] d,
                           input logic [15:0] exp_bits, input int n, input bit hold);
    len   = l;
    data  = d;
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    len  = ~l;
    data = ~d;
    chk({tag, "_state_start"}, 8'(state), 8'd1);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_bit%0d", tag, i), 8'(serout), 8'(exp_bits[n-1-i]));
      chk($sformatf("%s_busy%0d", tag, i), 8'({busy, done}), 8'b10);
      tick();
    end
    chk({tag, "_done_pulse"}, 8'({serout, busy, done}), 8'b111);
    chk({tag, "_state_done"}, 8'(state), 8'd5);
    tick();
    chk({tag, "_idle_after"}, 8'({serout, busy, done}), 8'b100);
    chk({tag, "_state_idle"}, 8'(state), 8'd0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    len   = 3'd0;
    data  = 8'h00;
    #2;
    chk("reset_outputs", 8'({serout, busy, done}), 8'b100);
    chk("reset_state", 8'(state), 8'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("idle_outputs", 8'({serout, busy, done}), 8'b100);

    // len=7, data=A5: 0 | 111 | 10100101
    run_frame("l7_a5", 3'd7, 8'hA5, 16'h07A5, 12, 1'b0);
    // len=0, data=80: 0 | 000 | 1
    run_frame("l0_80", 3'd0, 8'h80, 16'h0001, 5, 1'b0);
    // len=3, data=6C: 0 | 011 | 0110
    run_frame("l3_6c", 3'd3, 8'h6C, 16'h0036, 8, 1'b0);
`ifdef FRAME_SERIALIZER_PARITY_EN
    // 0 | 010 | 110 | parity 0
    run_frame("par_c0", 3'd2, 8'hC0, 16'h002C, 8, 1'b0);
    // 0 | 010 | 111 | parity 1
    run_frame("par_e0", 3'd2, 8'hE0, 16'h002F, 8, 1'b0);
`else
    // 0 | 010 | 110, no parity bit
    run_frame("nopar_c0", 3'd2, 8'hC0, 16'h0016, 7, 1'b0);
`endif

    // Start held high: one frame, one IDLE cycle, then the next frame
    run_frame("b2b_a", 3'd7, 8'hA5, 16'h07A5, 12, 1'b1);
    run_frame("b2b_b", 3'd3, 8'h6C, 16'h0036, 8, 1'b0);

    // Reset in the middle of DATA
    len   = 3'd7;
    data  = 8'hA5;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("pre_rst_state_data", 8'(state), 8'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_outputs", 8'({serout, busy, done}), 8'b100);
    chk("async_rst_state", 8'(state), 8'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_idle", 8'({serout, busy, done}), 8'b100);
    chk("post_rst_state", 8'(state), 8'd0);
    run_frame("after_rst", 3'd7, 8'hA5, 16'h07A5, 12, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
